// File: rtl/echo_pkg.sv
// Shared types and constants for the multi-echo time-of-flight detector.
package echo_pkg;

  localparam int ECHO_MAX    = 4;
  localparam int ECHO_DATA_W = 18;
  localparam int ECHO_TOF_W  = 32;
  localparam int IDX_W       = $clog2(ECHO_MAX);
  localparam int HYST_SHIFT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_TRACK   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [ECHO_TOF_W-1:0]  tof;
    logic [ECHO_DATA_W-1:0] peak;
    logic [IDX_W-1:0]       idx;
  } echo_rec_t;

endpackage

// File: rtl/echo_fifo.sv
// Synchronous FIFO of echo records with a synchronous flush; head is shown combinationally.
module echo_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = ECHO_MAX
) (
  input  logic      clk_50M,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  echo_rec_t wdata,
  input  logic      pop,
  output logic      not_empty,
  output echo_rec_t rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  echo_rec_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rdata     = mem[rd_ptr];

  // NOTE: sequential state uses <= only, so every read in this block sees pre-edge values.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because its head drives the output record, which must read zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/echo_multi_tof.sv
// Multi-echo ToF detector: records up to MAX_ECHO (ToF, peak) pairs per shot into an output FIFO.
// Define ECHO_MT_HYST_EN to end an echo at corr_threshold - corr_threshold/8 instead of corr_threshold.
module echo_multi_tof
  import echo_pkg::*;
#(
  parameter int DATA_W   = ECHO_DATA_W,
  parameter int TOF_W    = ECHO_TOF_W,
  parameter int MAX_ECHO = ECHO_MAX,
  parameter int HOLD_W   = 16
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  input  logic                        sys_start_pulse,
  input  logic                        mag_valid_in,
  input  logic [DATA_W-1:0]           mag_in,
  input  logic [DATA_W-1:0]           corr_threshold,
  input  logic [HOLD_W-1:0]           holdoff_cyc,
  input  logic [TOF_W-1:0]            window_cyc,
  output logic                        echo_valid,
  input  logic                        echo_ready,
  output logic [TOF_W-1:0]            echo_tof,
  output logic [DATA_W-1:0]           echo_peak,
  output logic [$clog2(MAX_ECHO)-1:0] echo_idx,
  output logic [$clog2(MAX_ECHO):0]   echo_count,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = $clog2(MAX_ECHO) + 1;

  state_e            state;
  logic [TOF_W-1:0]  tof_cnt;
  logic [TOF_W-1:0]  ptof;
  logic [DATA_W-1:0] peak;
  logic [DATA_W-1:0] exit_thr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout;
  logic              above;
  logic              below;
  logic              push;
  logic              last_echo;
  echo_rec_t         push_rec;
  echo_rec_t         head_rec;

`ifdef ECHO_MT_HYST_EN
  assign exit_thr = corr_threshold - (corr_threshold >> HYST_SHIFT);
`else
  assign exit_thr = corr_threshold;
`endif

  assign busy      = (state == ST_ARMED) || (state == ST_TRACK) || (state == ST_HOLDOFF);
  assign done      = (state == ST_DONE);
  assign timeout   = busy && (window_cyc != '0) && (tof_cnt > window_cyc);
  assign above     = mag_valid_in && (mag_in >= corr_threshold);
  assign below     = mag_valid_in && (mag_in < exit_thr);
  // A timeout while tracking flushes the partial echo before the shot closes.
  assign push      = !sys_start_pulse && (state == ST_TRACK) && (timeout || below);
  assign last_echo = (cnt_q == CNT_W'(MAX_ECHO - 1));
  assign push_rec  = '{tof: ptof, peak: peak, idx: IDX_W'(cnt_q)};

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tof_cnt  <= '0;
      ptof     <= '0;
      peak     <= '0;
      hold_cnt <= '0;
      cnt_q    <= '0;
    end else if (sys_start_pulse) begin
      state   <= ST_ARMED;
      tof_cnt <= TOF_W'(1);
      cnt_q   <= '0;
    end else begin
      if (busy && (tof_cnt != '1)) tof_cnt <= tof_cnt + 1'b1;
      if (push) cnt_q <= cnt_q + 1'b1;
      case (state)
        ST_ARMED: begin
          if (timeout) state <= ST_DONE;
          else if (above) begin
            state <= ST_TRACK;
            peak  <= mag_in;
            ptof  <= tof_cnt;
          end
        end
        ST_TRACK: begin
          if (push) begin
            state    <= (timeout || last_echo) ? ST_DONE : ST_HOLDOFF;
            hold_cnt <= holdoff_cyc;
          end else if (mag_valid_in && (mag_in > peak)) begin
            peak <= mag_in;
            ptof <= tof_cnt;
          end
        end
        ST_HOLDOFF: begin
          // A hold-off of 0 or 1 both spend exactly one cycle here.
          if (timeout) state <= ST_DONE;
          else if (hold_cnt <= HOLD_W'(1)) state <= ST_ARMED;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  echo_fifo #(.DEPTH(MAX_ECHO)) u_fifo (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .flush     (sys_start_pulse),
    .push      (push),
    .wdata     (push_rec),
    .pop       (echo_ready),
    .not_empty (echo_valid),
    .rdata     (head_rec)
  );

  assign echo_tof   = head_rec.tof;
  assign echo_peak  = head_rec.peak;
  assign echo_idx   = head_rec.idx;
  assign echo_count = cnt_q;

endmodule

// File: doc/echo_multi_tof.md
# echo_multi_tof

Multi-echo time-of-flight detector for the ultrasound receive chain. It sits after the correlation stage and consumes the unsigned correlation magnitude stream. After each `sys_start_pulse` it records up to `MAX_ECHO` threshold-crossing echoes, each as a (ToF, peak) pair. Records drain through a valid/ready output port, so downstream logic can resolve multiple reflectors per shot instead of only a single hit.

## Interface
- `DATA_W`, 18: magnitude, threshold and peak width.
- `TOF_W`, 32: ToF counter width, in `clk_50M` cycles.
- `MAX_ECHO`, 4: echoes recorded per shot; also the output FIFO depth (≥2).
- `HOLD_W`, 16: hold-off length width.
- `clk_50M` in 1: system clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `sys_start_pulse` in 1: shot start (T0), one cycle wide.
- `mag_valid_in` in 1: `mag_in` is valid this cycle.
- `mag_in` in `DATA_W`: unsigned correlation magnitude.
- `corr_threshold` in `DATA_W`: detection threshold, unsigned.
- `holdoff_cyc` in `HOLD_W`: dead time after each recorded echo.
- `window_cyc` in `TOF_W`: listen window length; 0 means no timeout.
- `echo_valid` out 1: an echo record is available.
- `echo_ready` in 1: consumer accepts the record.
- `echo_tof` out `TOF_W`: ToF of the peak sample.
- `echo_peak` out `DATA_W`: peak magnitude.
- `echo_idx` out `$clog2(MAX_ECHO)`: echo ordinal within the shot, 0-based.
- `echo_count` out `$clog2(MAX_ECHO)+1`: echoes recorded in the current shot.
- `busy` out 1: shot in progress.
- `done` out 1: shot finished; held until the next start.

## Operation
- FSM states:
  - IDLE: waits for `sys_start_pulse`.
  - ARMED: below threshold, watching for an echo.
  - TRACK: above threshold, tracking the maximum.
  - HOLDOFF: dead time after a recorded echo.
  - DONE: shot finished.
- `sys_start_pulse` in any state:
  - Flushes the FIFO, clears `echo_count` and loads `tof_cnt` = 1.
  - Moves the FSM to ARMED.
  - Start takes priority over every other event in that cycle, including a mid-shot start.
- `tof_cnt` increments every cycle while `busy`. It saturates at all-ones. A sample's ToF is `tof_cnt` in the cycle its `mag_valid_in` is high.
- ARMED: a valid sample with `mag_in >= corr_threshold` moves the FSM to TRACK and sets peak = `mag_in` and ptof = its ToF.
- TRACK:
  - A valid sample with `mag_in > peak` (strictly greater) updates peak and ptof; on ties the first sample is kept.
  - A valid sample below the exit threshold writes the record {ptof, peak, idx} and increments `echo_count`.
  - After that write the FSM goes to DONE if `echo_count` reaches `MAX_ECHO`, otherwise to HOLDOFF.
- HOLDOFF:
  - Ignores samples for `holdoff_cyc` clock cycles, then returns to ARMED.
  - If `holdoff_cyc` = 0, the FSM returns to ARMED on the next cycle.
- Timeout: with `window_cyc` ≠ 0, `tof_cnt` > `window_cyc` moves the FSM to DONE. If the FSM is in TRACK at that point, the partial echo is written first.
- `mag_valid_in` is ignored in IDLE, HOLDOFF and DONE.
- Output port:
  - `echo_valid` = FIFO not empty.
  - A pop happens on `echo_valid && echo_ready`.
  - Outputs are held stable while `echo_valid && !echo_ready`.
  - The FIFO cannot overflow within a shot because its depth is `MAX_ECHO`.
- `busy` is high in ARMED, TRACK and HOLDOFF. `done` is high in DONE only.

## Timing
- Reset: FSM = IDLE, FIFO empty, `echo_valid` = 0, `echo_tof` = 0, `echo_peak` = 0, `echo_idx` = 0, `echo_count` = 0, `busy` = 0, `done` = 0, `tof_cnt` = 0. Reset mid-shot discards all state.
- A sample sampled at edge t that ends TRACK gives `echo_valid` = 1 from cycle t+1 if the FIFO was empty.
- `busy` rises one cycle after the start pulse. `done` rises one cycle after the terminating event.
- FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
- A start coinciding with a pop: the flush wins.

## Configuration
- `ECHO_MT_HYST_EN` defined: exit threshold = `corr_threshold` − (`corr_threshold` >> 3), computed unsigned, no underflow possible. This suppresses chatter on noisy edges.
- Not defined: exit threshold = `corr_threshold`, so TRACK ends when `mag_in < corr_threshold`.

## Structure
- `echo_pkg` holds:
  - the FSM state enum;
  - the `echo_rec_t` struct {tof, peak, idx};
  - the localparams `IDX_W = $clog2(MAX_ECHO)` and `HYST_SHIFT = 3`.
- Sub-module `echo_fifo`: synchronous FIFO, depth `MAX_ECHO`, holding `echo_rec_t`, with synchronous flush. Both the FSM and the counters stay in `echo_multi_tof`.

## Test plan
- Single echo: threshold 1000; samples 0, 1200 @ToF 500, 1800 @550, 900 @600 → one record with tof = 550, peak = 1800, idx = 0; `echo_count` = 1.
- Two echoes with holdoff 100: pulses peaking at 1500 @1000 and 2000 @1400 → records (1000, 1500, 0) then (1400, 2000, 1), in order.
- Hold-off suppression: holdoff 500; a second pulse at 200 cycles after the first exit → not recorded; `echo_count` = 1.
- Window timeout: `window_cyc` = 800, still in TRACK at 801 → partial record written, then `done` = 1 and `busy` = 0.
- Backpressure and MAX_ECHO: `echo_ready` = 0 with 5 pulses and `MAX_ECHO` = 4 → 4 records, `done` after the 4th, outputs held stable; `echo_ready` = 1 drains idx 0..3.
- Restart and hysteresis:
  - Start mid-shot flushes the FIFO and `tof_cnt` = 1 next cycle.
  - With `ECHO_MT_HYST_EN`, threshold 1000: a dip to 900 keeps TRACK; 870 ends it.
